// File: rtl/mont_mul_pkg.sv
// mont_mul_pkg: shared types and constants for the Montgomery multiplier.
//   MONT_DEFAULT_WIDTH : default operand width, taken from the ECC-wide MAX_BITS
//   mont_state_e       : 2-bit control FSM state encoding
`ifndef MAX_BITS
`define MAX_BITS 256
`endif

package mont_mul_pkg;
    localparam int MONT_DEFAULT_WIDTH = `MAX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mont_state_e;
endpackage

// File: rtl/mont_mul_step.sv
// mont_mul_step: one combinational radix-2 Montgomery iteration.
//   s      : running accumulator (WIDTH+1 bits, kept below 2n)
//   b      : multiplier operand
//   a_bit  : current multiplicand bit (LSB of the shifted a register)
//   n      : odd modulus
//   s_next : (s + a_bit*b [+ n if odd]) / 2
module mont_mul_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] b,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH:0]   s_next
);
    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;
    logic             unused_lsb;

    always_comb begin
        t_add = {1'b0, s} + (a_bit ? {2'b00, b} : '0);
        // Adding odd n to an odd sum makes it even, so the shift is exact.
        t_red = t_add[0] ? t_add + {2'b00, n} : t_add;
    end

    // The dropped LSB is always zero after reduction.
    assign {s_next, unused_lsb} = t_red;
endmodule

// File: rtl/mont_mul.sv
// mont_mul: bit-serial radix-2 Montgomery multiplier, o_result = a*b*2^-WIDTH mod n.
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-low reset
//   i_start    : start request, only honoured in IDLE
//   i_n        : odd modulus > 1, held stable by the upstream stage for the whole op
//   i_a, i_b   : operands < i_n, captured on the accepted start
//   o_result   : registered product, held from one FIX to the next
//   o_finished : registered one-cycle completion pulse, WIDTH+2 edges after start
module mont_mul
    import mont_mul_pkg::*;
#(
    parameter int WIDTH = MONT_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mont_state_e      state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH:0]   s_r, s_step, s_fix;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] fix_res;
    logic             unused_fix_msb;

    mont_mul_step #(.WIDTH(WIDTH)) u_step (
        .s      (s_r),
        .b      (b_r),
        .a_bit  (a_r[0]),
        .n      (i_n),
        .s_next (s_step)
    );

    // Final conditional subtraction; s_r < 2n so one subtraction suffices.
    always_comb begin
        s_fix = (s_r >= {1'b0, i_n}) ? s_r - {1'b0, i_n} : s_r;
    end
    assign {unused_fix_msb, fix_res} = s_fix;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_CALC;
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_r        <= '0;
            b_r        <= '0;
            s_r        <= '0;
            cnt        <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
        end else begin
            o_finished <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        a_r <= i_a;
                        b_r <= i_b;
                        s_r <= '0;
                        cnt <= '0;
                    end
                end
                ST_CALC: begin
                    s_r <= s_step;
                    a_r <= a_r >> 1;
                    cnt <= cnt + CW'(1);
                end
                ST_FIX:  o_result <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_mul.sv
// tb_mont_mul: randomized self-checking bench for mont_mul at WIDTH=8 and WIDTH=256.
module tb_mont_mul;
    import mont_mul_pkg::*;

    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         start8, start256;
    logic [7:0]   n8, a8, b8, res8;
    logic         fin8;
    logic [255:0] n256, a256, b256, res256;
    logic         fin256;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mont_mul #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_n(n8),
        .i_a(a8), .i_b(b8), .o_result(res8), .o_finished(fin8)
    );

    mont_mul #(.WIDTH(256)) u_dut256 (
        .i_clk(clk), .i_rst(rst), .i_start(start256), .i_n(n256),
        .i_a(a256), .i_b(b256), .o_result(res256), .o_finished(fin256)
    );

    // Reference: (a*b mod n) * (2^-W mod n) mod n, with 2^-1 applied as modular halving.
    function automatic int model8(int a, int b, int n);
        int r = 1;
        for (int i = 0; i < 8; i++) r = (r % 2 == 0) ? r / 2 : (r + n) / 2;
        return ((a * b) % n) * r % n;
    endfunction

    function automatic logic [255:0] model256(logic [255:0] a, logic [255:0] b, logic [255:0] n);
        logic [256:0] h;
        logic [511:0] t, nn;
        h = 257'd1;
        for (int i = 0; i < 256; i++) h = h[0] ? (h + {1'b0, n}) >> 1 : h >> 1;
        nn = {256'b0, n};
        t  = ({256'b0, a} * {256'b0, b}) % nn;
        t  = (t * {255'b0, h}) % nn;
        return t[255:0];
    endfunction

    function automatic logic [255:0] rand_below(logic [255:0] n);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r % n;
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output int lat);
        @(negedge clk); a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (fin8) begin lat = i; break; end
        end
        res = res8;
    endtask

    task automatic op256(input logic [255:0] a, input logic [255:0] b,
                         output logic [255:0] res, output int lat);
        @(negedge clk); a256 = a; b256 = b; start256 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start256 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (fin256) begin lat = i; break; end
        end
        res = res256;
    endtask

    task automatic test_reset();
        rst = 1'b0; start8 = 1'b0; start256 = 1'b0;
        n8 = 8'd13; a8 = 8'd0; b8 = 8'd0;
        n256 = P256; a256 = '0; b256 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (res8 !== 8'd0) begin n_fail++; $display("FAIL reset_res8 got=%0d exp=0", res8); end
        n_checks++;
        if (fin8 !== 1'b0) begin n_fail++; $display("FAIL reset_fin8 got=%b exp=0", fin8); end
        n_checks++;
        if (res256 !== '0) begin n_fail++; $display("FAIL reset_res256 got=%h exp=0", res256); end
        n_checks++;
        if (fin256 !== 1'b0) begin n_fail++; $display("FAIL reset_fin256 got=%b exp=0", fin256); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] r;
        int lat;
        int va[3] = '{5, 1, 0};
        int vb[3] = '{7, 3, 12};
        int ve[3] = '{1, 9, 0};
        n8 = 8'd13;
        for (int k = 0; k < 3; k++) begin
            op8(8'(va[k]), 8'(vb[k]), r, lat);
            n_checks++;
            if (lat !== 10) begin n_fail++; $display("FAIL basic_latency[%0d] got=%0d exp=10", k, lat); end
            n_checks++;
            if (r !== 8'(ve[k])) begin n_fail++; $display("FAIL basic_result[%0d] got=%0d exp=%0d", k, r, ve[k]); end
            n_checks++;
            if (r !== 8'(model8(va[k], vb[k], 13)))
                begin n_fail++; $display("FAIL basic_model[%0d] got=%0d exp=%0d", k, r, model8(va[k], vb[k], 13)); end
        end
    endtask

    task automatic test_n255();
        logic [7:0] r;
        int lat, a, b, e;
        n8 = 8'd255;
        for (int k = 0; k < 305; k++) begin
            case (k)
                0: begin a = 0;   b = 0;   end
                1: begin a = 254; b = 254; end
                2: begin a = 1;   b = 254; end
                3: begin a = 254; b = 1;   end
                4: begin a = 128; b = 200; end
                default: begin a = $urandom_range(0, 254); b = $urandom_range(0, 254); end
            endcase
            e = model8(a, b, 255);
            op8(8'(a), 8'(b), r, lat);
            n_checks++;
            if (r !== 8'(e) || lat !== 10)
                begin n_fail++; $display("FAIL n255 a=%0d b=%0d got=%0d lat=%0d exp=%0d lat=10", a, b, r, lat, e); end
            n_checks++;
            if (r >= 8'd255) begin n_fail++; $display("FAIL n255_range got=%0d exp<255", r); end
        end
    endtask

    task automatic test_p256();
        logic [255:0] a, b, r, e;
        int lat;
        n256 = P256;
        for (int k = 0; k < 41; k++) begin
            if (k == 0) begin a = 256'd1; b = 256'd1; end
            else begin a = rand_below(P256); b = rand_below(P256); end
            e = model256(a, b, P256);
            op256(a, b, r, lat);
            n_checks++;
            if (lat !== 258) begin n_fail++; $display("FAIL p256_latency[%0d] got=%0d exp=258", k, lat); end
            n_checks++;
            if (r !== e) begin n_fail++; $display("FAIL p256_result[%0d] got=%h exp=%h", k, r, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea[3], eb[3];
        int         pulses[$];
        logic [7:0] pres[$];
        n8 = 8'd13;
        for (int k = 0; k < 3; k++) begin
            ea[k] = 8'($urandom_range(0, 12));
            eb[k] = 8'($urandom_range(0, 12));
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c < 33 && c % 11 == 0) begin
                start8 = 1'b1; a8 = ea[c / 11]; b8 = eb[c / 11];
            end else if (c < 33) begin
                start8 = 1'($urandom_range(0, 1));
                a8 = 8'($urandom_range(0, 12));
                b8 = 8'($urandom_range(0, 12));
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (fin8) begin pulses.push_back(c); pres.push_back(res8); end
        end
        n_checks++;
        if (pulses.size() !== 3) begin n_fail++; $display("FAIL b2b_pulse_count got=%0d exp=3", pulses.size()); end
        for (int k = 0; k < 3 && k < pulses.size(); k++) begin
            n_checks++;
            if (pulses[k] !== 11 * k + 10)
                begin n_fail++; $display("FAIL b2b_pulse_pos[%0d] got=%0d exp=%0d", k, pulses[k], 11 * k + 10); end
            n_checks++;
            if (pres[k] !== 8'(model8(int'(ea[k]), int'(eb[k]), 13)))
                begin n_fail++; $display("FAIL b2b_result[%0d] got=%0d exp=%0d", k, pres[k], model8(int'(ea[k]), int'(eb[k]), 13)); end
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [7:0] r;
        int lat, seen;
        n8 = 8'd13;
        op8(8'd5, 8'd7, r, lat);
        n_checks++;
        if (r !== 8'd1) begin n_fail++; $display("FAIL abort_prep got=%0d exp=1", r); end
        @(negedge clk); a8 = 8'd9; b8 = 8'd11; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (res8 !== 8'd0) begin n_fail++; $display("FAIL abort_res got=%0d exp=0", res8); end
        n_checks++;
        if (fin8 !== 1'b0) begin n_fail++; $display("FAIL abort_fin got=%b exp=0", fin8); end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (fin8) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_pulse got=%0d exp=0", seen); end
        op8(8'd9, 8'd11, r, lat);
        n_checks++;
        if (r !== 8'(model8(9, 11, 13)) || lat !== 10)
            begin n_fail++; $display("FAIL abort_recover got=%0d lat=%0d exp=%0d lat=10", r, lat, model8(9, 11, 13)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_n255();
        test_p256();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
